// File: rtl/piezo_burst_sequencer.sv
// Burst sequencer for an array of piezo transmitters: programmable square-wave bursts
// fired on all enabled channels at once, or one channel after another with a stagger delay.
module piezo_burst_sequencer #(
  parameter int NUM_CH = 61,
  parameter int DIV_W  = 16,
  parameter int CNT_W  = 8,
  parameter int DLY_W  = 16
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [CNT_W-1:0]  cfg_pulses,
  input  logic [DLY_W-1:0]  cfg_delay,
  input  logic              cfg_mode,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic              start,
  input  logic              abort,
  input  logic              piezo_enable_in,
  output logic [NUM_CH-1:0] piezo_out,
  output logic              piezo_enable,
  output logic [5:0]        active_ch,
  output logic              busy,
  output logic              done,
  output logic [2:0]        status
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DELAY,
    S_BURST,
    S_DONE
  } state_t;

  state_t             r_state;

  logic [DIV_W-1:0]   r_div;
  logic [CNT_W-1:0]   r_pulses;
  logic [DLY_W-1:0]   r_delay;
  logic               r_mode;
  logic [NUM_CH-1:0]  r_mask;

  logic [5:0]         r_ch;
  logic [DIV_W-1:0]   r_half;
  logic               r_high;
  logic [CNT_W-1:0]   r_pulse;
  logic [DLY_W-1:0]   r_dly;

  logic               r_cfgErr;
  logic               r_aborted;

  logic [5:0]         w_firstCh;
  logic [5:0]         w_nextCh;
  logic               w_nextValid;
  logic [NUM_CH-1:0]  w_patFirst;
  logic [NUM_CH-1:0]  w_patCur;
  logic [NUM_CH-1:0]  w_patNext;
  logic               w_running;
  logic               w_lastDelay;
  logic               w_lastHalf;
  logic               w_lastPulse;

  assign status      = {r_cfgErr, r_aborted, busy};
  assign w_running   = (r_state == S_LOAD) || (r_state == S_DELAY) || (r_state == S_BURST);
  assign w_lastDelay = (r_dly == r_delay - DLY_W'(1));
  assign w_lastHalf  = (r_half == r_div);
  assign w_lastPulse = (r_pulse == r_pulses - CNT_W'(1));

  // Channel search: lowest set bit of the live mask for LOAD, and the next set
  // bit above the current channel of the shadow mask for sequential advance.
  always_comb begin
    w_firstCh   = '0;
    w_nextCh    = '0;
    w_nextValid = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_mask[i]) begin
        w_firstCh = 6'(i);
      end
      if (r_mask[i] && (i > int'(r_ch))) begin
        w_nextCh    = 6'(i);
        w_nextValid = 1'b1;
      end
    end
  end

  always_comb begin
    w_patFirst = '0;
    w_patCur   = '0;
    w_patNext  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_patFirst[i] = cfg_mode ? (i == int'(w_firstCh)) : ch_mask[i];
      w_patCur[i]   = r_mode ? (i == int'(r_ch)) : r_mask[i];
      w_patNext[i]  = (i == int'(w_nextCh));
    end
  end

  // Outputs are computed from the next-state counters so each registered value
  // lines up with the phase it belongs to; a low external gate freezes everything.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_state      <= S_IDLE;
      r_div        <= '0;
      r_pulses     <= '0;
      r_delay      <= '0;
      r_mode       <= 1'b0;
      r_mask       <= '0;
      r_ch         <= '0;
      r_half       <= '0;
      r_high       <= 1'b0;
      r_pulse      <= '0;
      r_dly        <= '0;
      r_cfgErr     <= 1'b0;
      r_aborted    <= 1'b0;
      piezo_out    <= '0;
      piezo_enable <= 1'b0;
      active_ch    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      if (w_running && abort) begin
        r_state      <= S_DONE;
        r_aborted    <= 1'b1;
        done         <= 1'b1;
        piezo_out    <= '0;
        piezo_enable <= 1'b0;
        active_ch    <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start && !abort) begin
              r_state   <= S_LOAD;
              r_cfgErr  <= 1'b0;
              r_aborted <= 1'b0;
              busy      <= 1'b1;
            end
          end

          S_LOAD: begin
            r_div    <= cfg_div;
            r_pulses <= cfg_pulses;
            r_delay  <= cfg_delay;
            r_mode   <= cfg_mode;
            r_mask   <= ch_mask;
            r_half   <= '0;
            r_high   <= 1'b1;
            r_pulse  <= '0;
            r_dly    <= '0;
            if ((ch_mask == '0) || (cfg_pulses == '0)) begin
              r_cfgErr <= 1'b1;
              r_state  <= S_DONE;
              done     <= 1'b1;
            end else begin
              r_ch         <= w_firstCh;
              piezo_enable <= 1'b1;
              if (cfg_delay != '0) begin
                r_state <= S_DELAY;
              end else begin
                r_state   <= S_BURST;
                piezo_out <= w_patFirst;
                active_ch <= cfg_mode ? w_firstCh : 6'd0;
              end
            end
          end

          S_DELAY: begin
            if (piezo_enable_in) begin
              if (w_lastDelay) begin
                r_dly     <= '0;
                r_state   <= S_BURST;
                piezo_out <= w_patCur;
                active_ch <= r_mode ? r_ch : 6'd0;
              end else begin
                r_dly <= r_dly + DLY_W'(1);
              end
            end
          end

          S_BURST: begin
            if (!piezo_enable_in) begin
              piezo_out <= '0;
            end else if (!w_lastHalf) begin
              r_half    <= r_half + DIV_W'(1);
              piezo_out <= r_high ? w_patCur : '0;
            end else begin
              r_half <= '0;
              if (r_high) begin
                r_high    <= 1'b0;
                piezo_out <= '0;
              end else if (!w_lastPulse) begin
                r_pulse   <= r_pulse + CNT_W'(1);
                r_high    <= 1'b1;
                piezo_out <= w_patCur;
              end else if (r_mode && w_nextValid) begin
                r_ch    <= w_nextCh;
                r_pulse <= '0;
                r_high  <= 1'b1;
                if (r_delay != '0) begin
                  r_state   <= S_DELAY;
                  piezo_out <= '0;
                  active_ch <= '0;
                end else begin
                  piezo_out <= w_patNext;
                  active_ch <= w_nextCh;
                end
              end else begin
                r_state      <= S_DONE;
                done         <= 1'b1;
                piezo_out    <= '0;
                piezo_enable <= 1'b0;
                active_ch    <= '0;
              end
            end
          end

          S_DONE: begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end

          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_piezo_burst_sequencer.sv
// Directed bench for piezo_burst_sequencer with a 4-channel instance; expected
// waveforms are hand-derived cycle tables, cycle 0 being the cycle start is held high.
module tb_piezo_burst_sequencer;

  localparam int NUM_CH = 4;
  localparam int DIV_W  = 16;
  localparam int CNT_W  = 8;
  localparam int DLY_W  = 16;

  logic              clk_clk;
  logic              reset_reset_n;
  logic [DIV_W-1:0]  cfg_div;
  logic [CNT_W-1:0]  cfg_pulses;
  logic [DLY_W-1:0]  cfg_delay;
  logic              cfg_mode;
  logic [NUM_CH-1:0] ch_mask;
  logic              start;
  logic              abort;
  logic              piezo_enable_in;
  logic [NUM_CH-1:0] piezo_out;
  logic              piezo_enable;
  logic [5:0]        active_ch;
  logic              busy;
  logic              done;
  logic [2:0]        status;

  int checkCount;
  int failCount;

  logic [NUM_CH-1:0] obsOut    [32];
  logic              obsDone   [32];
  logic              obsBusy   [32];
  logic              obsEn     [32];
  logic [2:0]        obsStatus [32];
  logic [5:0]        obsAct    [32];

  piezo_burst_sequencer #(
    .NUM_CH(NUM_CH),
    .DIV_W (DIV_W),
    .CNT_W (CNT_W),
    .DLY_W (DLY_W)
  ) dut (
    .clk_clk        (clk_clk),
    .reset_reset_n  (reset_reset_n),
    .cfg_div        (cfg_div),
    .cfg_pulses     (cfg_pulses),
    .cfg_delay      (cfg_delay),
    .cfg_mode       (cfg_mode),
    .ch_mask        (ch_mask),
    .start          (start),
    .abort          (abort),
    .piezo_enable_in(piezo_enable_in),
    .piezo_out      (piezo_out),
    .piezo_enable   (piezo_enable),
    .active_ch      (active_ch),
    .busy           (busy),
    .done           (done),
    .status         (status)
  );

  initial clk_clk = 1'b0;
  always #5 clk_clk = ~clk_clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [DIV_W-1:0] div, input logic [CNT_W-1:0] pulses,
                               input logic [DLY_W-1:0] delay, input logic mode,
                               input logic [NUM_CH-1:0] mask);
    cfg_div    = div;
    cfg_pulses = pulses;
    cfg_delay  = delay;
    cfg_mode   = mode;
    ch_mask    = mask;
  endtask

  task automatic runCycles(input int n, input int abortCyc, input int restartCyc,
                           input int holdFirst, input int holdLast);
    for (int c = 0; c < n; c++) begin
      @(posedge clk_clk);
      #1;
      start           = (c == 0) || (c == restartCyc);
      abort           = (c == abortCyc);
      piezo_enable_in = !((c >= holdFirst) && (c <= holdLast));
      @(negedge clk_clk);
      obsOut[c]    = piezo_out;
      obsDone[c]   = done;
      obsBusy[c]   = busy;
      obsEn[c]     = piezo_enable;
      obsStatus[c] = status;
      obsAct[c]    = active_ch;
    end
  endtask

  task automatic idleCycles(input int k);
    repeat (k) begin
      @(posedge clk_clk);
      #1;
      start           = 1'b0;
      abort           = 1'b0;
      piezo_enable_in = 1'b1;
    end
  endtask

  task automatic checkSimul(input string pre);
    logic [NUM_CH-1:0] expOut;
    for (int c = 0; c < 16; c++) begin
      expOut = ((c == 2) || (c == 3) || (c == 6) || (c == 7) || (c == 10) || (c == 11)) ? 4'b0101 : 4'b0000;
      checkOutput($sformatf("%s out c%0d", pre, c), 64'(obsOut[c]), 64'(expOut));
      checkOutput($sformatf("%s done c%0d", pre, c), 64'(obsDone[c]), 64'(c == 14));
    end
    checkOutput({pre, " busy c0"}, 64'(obsBusy[0]), 64'd0);
    checkOutput({pre, " busy c1"}, 64'(obsBusy[1]), 64'd1);
    checkOutput({pre, " busy c14"}, 64'(obsBusy[14]), 64'd1);
    checkOutput({pre, " busy c15"}, 64'(obsBusy[15]), 64'd0);
    checkOutput({pre, " status c15"}, 64'(obsStatus[15]), 64'd0);
    checkOutput({pre, " en c1"}, 64'(obsEn[1]), 64'd0);
    checkOutput({pre, " en c2"}, 64'(obsEn[2]), 64'd1);
    checkOutput({pre, " en c13"}, 64'(obsEn[13]), 64'd1);
    checkOutput({pre, " en c14"}, 64'(obsEn[14]), 64'd0);
  endtask

  initial begin
    logic [NUM_CH-1:0] expOut;
    checkCount      = 0;
    failCount       = 0;
    reset_reset_n   = 1'b0;
    start           = 1'b0;
    abort           = 1'b0;
    piezo_enable_in = 1'b1;
    applyStimulus(16'd1, 8'd3, 16'd0, 1'b0, 4'b0101);

    repeat (3) @(negedge clk_clk);
    checkOutput("rst out", 64'(piezo_out), 64'd0);
    checkOutput("rst en", 64'(piezo_enable), 64'd0);
    checkOutput("rst act", 64'(active_ch), 64'd0);
    checkOutput("rst busy", 64'(busy), 64'd0);
    checkOutput("rst done", 64'(done), 64'd0);
    checkOutput("rst status", 64'(status), 64'd0);
    reset_reset_n = 1'b1;
    idleCycles(2);

    $display("[TB] simultaneous burst");
    applyStimulus(16'd1, 8'd3, 16'd0, 1'b0, 4'b0101);
    runCycles(16, -1, -1, -1, -1);
    checkSimul("s1");
    idleCycles(2);

    $display("[TB] sequential burst with stagger");
    applyStimulus(16'd0, 8'd1, 16'd3, 1'b1, 4'b1011);
    runCycles(19, -1, -1, -1, -1);
    for (int c = 0; c < 19; c++) begin
      expOut = (c == 5) ? 4'b0001 : (c == 10) ? 4'b0010 : (c == 15) ? 4'b1000 : 4'b0000;
      checkOutput($sformatf("s2 out c%0d", c), 64'(obsOut[c]), 64'(expOut));
      checkOutput($sformatf("s2 done c%0d", c), 64'(obsDone[c]), 64'(c == 17));
    end
    checkOutput("s2 act c5", 64'(obsAct[5]), 64'd0);
    checkOutput("s2 act c10", 64'(obsAct[10]), 64'd1);
    checkOutput("s2 act c15", 64'(obsAct[15]), 64'd3);
    checkOutput("s2 en c1", 64'(obsEn[1]), 64'd0);
    checkOutput("s2 en c2", 64'(obsEn[2]), 64'd1);
    checkOutput("s2 status c18", 64'(obsStatus[18]), 64'd0);
    idleCycles(2);

    $display("[TB] empty mask and zero pulse count");
    for (int k = 0; k < 2; k++) begin
      if (k == 0) applyStimulus(16'd1, 8'd3, 16'd0, 1'b0, 4'b0000);
      else        applyStimulus(16'd1, 8'd0, 16'd0, 1'b0, 4'b0101);
      runCycles(4, -1, -1, -1, -1);
      for (int c = 0; c < 4; c++) begin
        checkOutput($sformatf("s3.%0d out c%0d", k, c), 64'(obsOut[c]), 64'd0);
        checkOutput($sformatf("s3.%0d done c%0d", k, c), 64'(obsDone[c]), 64'(c == 2));
      end
      checkOutput($sformatf("s3.%0d status c1", k), 64'(obsStatus[1]), 64'b001);
      checkOutput($sformatf("s3.%0d status c3", k), 64'(obsStatus[3]), 64'b100);
      idleCycles(2);
    end

    $display("[TB] abort then restart");
    applyStimulus(16'd1, 8'd3, 16'd0, 1'b0, 4'b0101);
    runCycles(12, 7, 9, -1, -1);
    for (int c = 0; c < 12; c++) begin
      expOut = ((c == 2) || (c == 3) || (c == 6) || (c == 7) || (c == 11)) ? 4'b0101 : 4'b0000;
      checkOutput($sformatf("s4 out c%0d", c), 64'(obsOut[c]), 64'(expOut));
      checkOutput($sformatf("s4 done c%0d", c), 64'(obsDone[c]), 64'(c == 8));
    end
    checkOutput("s4 status c9", 64'(obsStatus[9]), 64'b010);
    checkOutput("s4 status c10", 64'(obsStatus[10]), 64'b001);
    idleCycles(16);

    $display("[TB] external hold");
    applyStimulus(16'd1, 8'd3, 16'd0, 1'b0, 4'b0101);
    runCycles(19, -1, -1, 2, 4);
    for (int c = 0; c < 19; c++) begin
      expOut = ((c == 2) || (c == 6) || (c == 9) || (c == 10) || (c == 13) || (c == 14)) ? 4'b0101 : 4'b0000;
      checkOutput($sformatf("s5 out c%0d", c), 64'(obsOut[c]), 64'(expOut));
      checkOutput($sformatf("s5 done c%0d", c), 64'(obsDone[c]), 64'(c == 17));
    end
    checkOutput("s5 en c4", 64'(obsEn[4]), 64'd1);
    idleCycles(2);

    $display("[TB] reset mid-burst");
    applyStimulus(16'd1, 8'd3, 16'd0, 1'b0, 4'b0101);
    runCycles(4, -1, -1, -1, -1);
    checkOutput("s6 out c3", 64'(obsOut[3]), 64'b0101);
    #1;
    reset_reset_n = 1'b0;
    #1;
    checkOutput("s6 async out", 64'(piezo_out), 64'd0);
    checkOutput("s6 async busy", 64'(busy), 64'd0);
    checkOutput("s6 async en", 64'(piezo_enable), 64'd0);
    repeat (2) @(posedge clk_clk);
    @(negedge clk_clk);
    checkOutput("s6 held done", 64'(done), 64'd0);
    checkOutput("s6 held status", 64'(status), 64'd0);
    reset_reset_n = 1'b1;
    idleCycles(2);
    @(negedge clk_clk);
    checkOutput("s6 post done", 64'(done), 64'd0);
    checkOutput("s6 post busy", 64'(busy), 64'd0);
    runCycles(16, -1, -1, -1, -1);
    checkSimul("s6");

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
